// File: rtl/maxpool_row_buffer_array.sv
// Lane-parallel row buffer for the max-pool stage.
// FIFO mode: a line-delay FIFO with valid/ready on both sides.
// POOL mode: even rows are buffered; each odd-row word is merged with the
// buffered word of the same column by a lane-wise signed max.
module maxpool_row_buffer_array #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_FIFO   = 16,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           cfg_mode,
  input  logic [AW:0]                    cfg_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*NUM_FIFO-1:0] data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*NUM_FIFO-1:0] data_out,
  output logic [AW:0]                    count,
  output logic                           full,
  output logic                           empty
);

  localparam int            WW       = DATA_WIDTH * NUM_FIFO;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {S_FIFO, S_EVEN, S_ODD} state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     col_q, col_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [WW-1:0]   data_out_q, data_out_d;
  logic [WW-1:0]   mem_q [DEPTH];

  logic [WW-1:0]   head;
  logic [WW-1:0]   max_word;
  logic            push, pop, full_w, in_ready_w, last_col;

  assign head      = mem_q[rd_ptr_q];
  assign full_w    = mode_q ? (count_q == len_q) : (count_q == DEPTH_C);
  assign last_col  = (col_q == len_q - ONE_C);

  assign in_ready  = in_ready_w;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = (count_q == '0);

  // Lane-wise signed max of the buffered head and the incoming odd-row word
  always_comb begin
    max_word = '0;
    for (int unsigned i = 0; i < NUM_FIFO; i++) begin
      if ($signed(head[i*DATA_WIDTH +: DATA_WIDTH]) > $signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]))
        max_word[i*DATA_WIDTH +: DATA_WIDTH] = head[i*DATA_WIDTH +: DATA_WIDTH];
      else
        max_word[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, handshake and pointer logic
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    col_d       = col_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    push        = 1'b0;
    pop         = 1'b0;
    in_ready_w  = 1'b0;

    if (clr) begin
      state_d     = cfg_mode ? S_EVEN : S_FIFO;
      mode_d      = cfg_mode;
      len_d       = (cfg_len == '0 || cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
      col_d       = '0;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FIFO: begin
          in_ready_w = !full_w;
          push       = in_valid && in_ready_w;
          pop        = (count_q != '0) && (!out_valid_q || out_ready);
          if (pop) begin
            data_out_d  = head;
            out_valid_d = 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        S_EVEN: begin
          in_ready_w = 1'b1;
          push       = in_valid;
          if (out_valid_q && out_ready) out_valid_d = 1'b0;
          if (push) begin
            if (last_col) begin
              col_d   = '0;
              state_d = S_ODD;
            end else begin
              col_d = col_q + ONE_C;
            end
          end
        end
        S_ODD: begin
          in_ready_w = !out_valid_q || out_ready;
          pop        = in_valid && in_ready_w;
          if (pop) begin
            data_out_d  = max_word;
            out_valid_d = 1'b1;
            if (last_col) begin
              col_d   = '0;
              state_d = S_EVEN;
            end else begin
              col_d = col_q + ONE_C;
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: state_d = S_FIFO;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + ONE_C;
      else if (pop && !push) count_d = count_q - ONE_C;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FIFO;
      mode_q      <= 1'b0;
      len_q       <= DEPTH_C;
      col_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      col_q       <= col_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  // Buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule
